// File: rtl/stage_mem_pkg.sv
// Shared encodings for the memory-access stage: RV32I load/store funct3 values,
// writeback select codes and the data-memory handshake FSM states.
package stage_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/stage_mem_store_alignment.sv
// Write-side alignment: byte enables, replicated store data and misalignment
// detection from funct3 and the low address bits (combinational).
module store_alignment
    import stage_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rs2,
    output logic [3:0]      o_we,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_misaligned
);

    logic [1:0] w_size;

    assign w_size = access_size(i_funct3);

    always_comb begin
        o_we         = '0;
        o_wdata      = i_rs2;
        o_misaligned = 1'b0;
        case (w_size)
            2'b00: begin
                o_we    = 4'b0001 << i_addr_lo;
                o_wdata = {(XLEN/8){i_rs2[7:0]}};
            end
            2'b01: begin
                o_we         = 4'b0011 << i_addr_lo;
                o_wdata      = {(XLEN/16){i_rs2[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            2'b10: begin
                o_we         = '1;
                o_wdata      = i_rs2;
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_we         = '0;
                o_wdata      = i_rs2;
                o_misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage between X and W: drives the data-memory req/gnt/rvalid
// handshake, stalls X while an access is outstanding and registers W fields.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validX,
    input  logic [2:0]      funct3X,
    input  logic [XLEN-1:0] alu_outX,
    input  logic [XLEN-1:0] rs2_dataX,
    input  logic            mem_readX,
    input  logic            mem_writeX,
    input  logic [XLEN-1:0] jump_result_plus4X,
    input  logic [1:0]      wb_selX,
    input  logic            reg_writeX,
    input  logic [4:0]      rdX,
    output logic            stallX,
    output logic            dmem_req,
    output logic [3:0]      dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            validW,
    output logic [2:0]      funct3W,
    output logic [XLEN-1:0] mem_adrW,
    output logic [XLEN-1:0] dinW,
    output logic [XLEN-1:0] alu_outW,
    output logic [XLEN-1:0] jump_result_plus4W,
    output logic [1:0]      wb_selW,
    output logic            reg_writeW,
    output logic [4:0]      rdW,
    output logic            misalignW
);

    mem_state_e      r_state;
    mem_state_e      w_state_nxt;

    logic            w_mem_access;
    logic            w_misaligned;
    logic            w_memop;
    logic            w_req;
    logic            w_complete;
    logic            w_stall;
    logic [3:0]      w_we;
    logic [XLEN-1:0] w_wdata;

    logic            r_validW;
    logic [2:0]      r_funct3W;
    logic [XLEN-1:0] r_mem_adrW;
    logic [XLEN-1:0] r_dinW;
    logic [XLEN-1:0] r_alu_outW;
    logic [XLEN-1:0] r_jump_result_plus4W;
    logic [1:0]      r_wb_selW;
    logic            r_reg_writeW;
    logic [4:0]      r_rdW;
    logic            r_misalignW;

    store_alignment #(
        .XLEN(XLEN)
    ) u_store_alignment (
        .i_funct3     (funct3X),
        .i_addr_lo    (alu_outX[1:0]),
        .i_rs2        (rs2_dataX),
        .o_we         (w_we),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    assign w_mem_access = validX & (mem_readX | mem_writeX);
    assign w_memop      = w_mem_access & ~w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = w_memop;
                if (w_memop) begin
                    if (!dmem_gnt) begin
                        w_state_nxt = ST_REQ;
                    end else if (mem_writeX) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (dmem_gnt) begin
                    if (mem_writeX) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset overrides the handshake combinationally so nothing leaks out mid-reset
    assign w_stall    = w_memop & ~w_complete & ~rst;
    assign stallX     = w_stall;
    assign dmem_req   = w_req & ~rst;
    assign dmem_we    = mem_writeX ? w_we : '0;
    assign dmem_addr  = {alu_outX[XLEN-1:2], 2'b00};
    assign dmem_wdata = w_wdata;

    always_ff @(posedge clk) begin
        if (rst || !validX || w_stall) begin
            r_validW             <= 1'b0;
            r_funct3W            <= '0;
            r_mem_adrW           <= '0;
            r_dinW               <= '0;
            r_alu_outW           <= '0;
            r_jump_result_plus4W <= '0;
            r_wb_selW            <= '0;
            r_reg_writeW         <= 1'b0;
            r_rdW                <= '0;
            r_misalignW          <= 1'b0;
        end else begin
            r_validW             <= 1'b1;
            r_funct3W            <= funct3X;
            r_mem_adrW           <= alu_outX;
            r_dinW               <= (w_memop && !mem_writeX) ? dmem_rdata : '0;
            r_alu_outW           <= alu_outX;
            r_jump_result_plus4W <= jump_result_plus4X;
            r_wb_selW            <= wb_selX;
            r_reg_writeW         <= reg_writeX & ~(w_mem_access & w_misaligned);
            r_rdW                <= rdX;
            r_misalignW          <= w_mem_access & w_misaligned;
        end
    end

    assign validW             = r_validW;
    assign funct3W            = r_funct3W;
    assign mem_adrW           = r_mem_adrW;
    assign dinW               = r_dinW;
    assign alu_outW           = r_alu_outW;
    assign jump_result_plus4W = r_jump_result_plus4W;
    assign wb_selW            = r_wb_selW;
    assign reg_writeW         = r_reg_writeW;
    assign rdW                = r_rdW;
    assign misalignW          = r_misalignW;

endmodule
